// File: rtl/vram_arb_pkg.sv
// Shared widths and CPU-side state encoding for the VRAM arbiter.
package vram_arb_pkg;
   localparam int VRAM_ADDR_W = 11;   // {row[4:0], col[5:0]}
   localparam int VRAM_DATA_W = 19;   // {rgb[2:0], char_index[15:0]}

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      ACK  = 2'd2
   } cpu_state_t;
endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA refresh fetches have absolute priority, CPU
// accesses are buffered and slotted into cycles the display does not need.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W = VRAM_ADDR_W,
   parameter int DATA_W = VRAM_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vga_rdn,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic [DATA_W-1:0] vga_data,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [7:0]        stall_cnt
);
   cpu_state_t        state;
   logic              cache_valid;
   logic [ADDR_W-1:0] cache_addr;
   logic              rdn_q;
   logic              vga_grant_q;
   logic              ready_q;
   logic              buf_we;
   logic [ADDR_W-1:0] buf_addr;
   logic [DATA_W-1:0] buf_wdata;
   logic              vga_need;
   logic              cpu_grant;

   // A falling vga_rdn (rdn_q still high) forces a fetch even on a cache hit.
   always_comb begin
      vga_need  = !vga_rdn && (!cache_valid || rdn_q || (vga_addr != cache_addr));
      cpu_grant = (state == PEND) && !vga_need && !reset;
      ram_addr  = cpu_grant ? buf_addr : vga_addr;
      ram_we    = cpu_grant && buf_we;
      ram_wdata = buf_wdata;
   end

   // Reset gates the handshake so a dropped access never shows a ready pulse.
   assign cpu_ready = ready_q && !reset;
   assign cpu_rdata = (cpu_ready && !buf_we) ? ram_rdata : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cache_valid <= 1'b0;
         cache_addr  <= '0;
         rdn_q       <= 1'b1;
         vga_grant_q <= 1'b0;
         vga_data    <= '0;
         ready_q     <= 1'b0;
         buf_we      <= 1'b0;
         buf_addr    <= '0;
         buf_wdata   <= '0;
         stall_cnt   <= 8'd0;
      end else begin
         rdn_q       <= vga_rdn;
         vga_grant_q <= vga_need;
         ready_q     <= 1'b0;
         if (vga_grant_q)
            vga_data <= ram_rdata;

         // Writing the word the display holds makes the cached copy stale.
         if (vga_need) begin
            cache_addr  <= vga_addr;
            cache_valid <= 1'b1;
         end else if (cpu_grant && buf_we && (buf_addr == cache_addr)) begin
            cache_valid <= 1'b0;
         end

         if ((state == PEND) && (stall_cnt != 8'hFF))
            stall_cnt <= stall_cnt + 8'd1;

         case (state)
            IDLE: if (cpu_req) begin
               buf_we    <= cpu_we;
               buf_addr  <= cpu_addr;
               buf_wdata <= cpu_wdata;
               state     <= PEND;
            end
            PEND: if (cpu_grant) begin
               ready_q <= 1'b1;
               state   <= ACK;
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a 1-cycle synchronous VRAM model.
module tb_vram_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        vga_rdn;
   logic [10:0] vga_addr;
   logic [18:0] vga_data;
   logic        cpu_req;
   logic        cpu_we;
   logic [10:0] cpu_addr;
   logic [18:0] cpu_wdata;
   logic        cpu_ready;
   logic [18:0] cpu_rdata;
   logic [10:0] ram_addr;
   logic        ram_we;
   logic [18:0] ram_wdata;
   logic [18:0] ram_rdata;
   logic [7:0]  stall_cnt;

   logic [18:0] mem [2048];
   int vectors = 0;
   int errors  = 0;

   vram_arbiter dut (
      .clk(clk), .reset(reset),
      .vga_rdn(vga_rdn), .vga_addr(vga_addr), .vga_data(vga_data),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Read-first synchronous VRAM.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      vga_rdn = 1'b1; vga_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      reset = 1'b1;
      tick();
      tick();
      #1;
      vectors++;
      if (cpu_ready !== 1'b0 || vga_data !== 19'h0 || stall_cnt !== 8'd0 ||
          cpu_rdata !== 19'h0 || ram_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: ready=%b vga_data=%h stall=%0d rdata=%h we=%b, want 0s",
                  cpu_ready, vga_data, stall_cnt, cpu_rdata, ram_we);
      end
      reset = 1'b0;
   endtask

   task automatic test_cpu_write();
      do_reset();
      tick();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h045; cpu_wdata = 19'h5_0041;
      #1;
      vectors++;
      if (ram_we !== 1'b0) begin
         errors++; $display("FAIL wr_cycle1_we: got %b want 0", ram_we);
      end
      tick();
      cpu_req = 1'b0;
      #1;
      vectors++;
      if (ram_we !== 1'b1 || ram_addr !== 11'h045 || ram_wdata !== 19'h5_0041 || cpu_ready !== 1'b0) begin
         errors++;
         $display("FAIL wr_cycle2_grant: we=%b addr=%h wdata=%h ready=%b want 1/045/50041/0",
                  ram_we, ram_addr, ram_wdata, cpu_ready);
      end
      tick(); #1;
      vectors++;
      if (cpu_ready !== 1'b1 || ram_we !== 1'b0) begin
         errors++; $display("FAIL wr_cycle3_ready: ready=%b we=%b want 1/0", cpu_ready, ram_we);
      end
      tick(); #1;
      vectors++;
      if (cpu_ready !== 1'b0 || mem[11'h045] !== 19'h5_0041 || stall_cnt !== 8'd1) begin
         errors++;
         $display("FAIL wr_after: ready=%b mem=%h stall=%0d want 0/50041/1",
                  cpu_ready, mem[11'h045], stall_cnt);
      end
   endtask

   task automatic test_cpu_read();
      tick();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h045;
      tick();
      cpu_req = 1'b0;
      #1;
      vectors++;
      if (ram_addr !== 11'h045 || ram_we !== 1'b0) begin
         errors++; $display("FAIL rd_grant: addr=%h we=%b want 045/0", ram_addr, ram_we);
      end
      tick(); #1;
      vectors++;
      if (cpu_ready !== 1'b1 || cpu_rdata !== 19'h5_0041) begin
         errors++; $display("FAIL rd_data: ready=%b rdata=%h want 1/50041", cpu_ready, cpu_rdata);
      end
   endtask

   task automatic test_contention();
      logic [18:0] exp_v, exp_c;
      exp_v = mem[11'h011];
      exp_c = mem[11'h020];
      vga_rdn = 1'b1;
      do_reset();
      tick();
      vga_rdn = 1'b0; vga_addr = 11'h010;
      tick();
      tick();
      vga_addr = 11'h011;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h020;
      #1;
      vectors++;
      if (ram_addr !== 11'h011 || ram_we !== 1'b0) begin
         errors++; $display("FAIL cont_vga_first: addr=%h we=%b want 011/0", ram_addr, ram_we);
      end
      tick();
      cpu_req = 1'b0;
      #1;
      vectors++;
      if (ram_addr !== 11'h020 || cpu_ready !== 1'b0) begin
         errors++; $display("FAIL cont_cpu_grant: addr=%h ready=%b want 020/0", ram_addr, cpu_ready);
      end
      tick(); #1;
      vectors++;
      if (cpu_ready !== 1'b1 || cpu_rdata !== exp_c || stall_cnt !== 8'd1 || vga_data !== exp_v) begin
         errors++;
         $display("FAIL cont_ack: ready=%b rdata=%h stall=%0d vga=%h want 1/%h/1/%h",
                  cpu_ready, cpu_rdata, stall_cnt, vga_data, exp_c, exp_v);
      end
   endtask

   task automatic test_cache_inval();
      tick();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h011; cpu_wdata = 19'h0_1234;
      tick();
      cpu_req = 1'b0;
      #1;
      vectors++;
      if (ram_we !== 1'b1 || ram_addr !== 11'h011) begin
         errors++; $display("FAIL inval_write: we=%b addr=%h want 1/011", ram_we, ram_addr);
      end
      tick(); #1;
      vectors++;
      if (cpu_ready !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 11'h011) begin
         errors++;
         $display("FAIL inval_refetch: ready=%b we=%b addr=%h want 1/0/011", cpu_ready, ram_we, ram_addr);
      end
      tick();
      tick(); #1;
      vectors++;
      if (vga_data !== 19'h0_1234) begin
         errors++; $display("FAIL inval_vga_data: got %h want 01234", vga_data);
      end
   endtask

   task automatic test_rdn_fall();
      logic [18:0] old_w;
      old_w = mem[11'h000];
      vga_rdn = 1'b0; vga_addr = 11'h000;
      do_reset();
      tick();
      vga_rdn = 1'b1;
      tick(); #1;
      vectors++;
      if (vga_data !== old_w) begin
         errors++; $display("FAIL rdn_first_fetch: got %h want %h", vga_data, old_w);
      end
      mem[11'h000] = 19'h7_ABCD;
      tick(); #1;
      vectors++;
      if (vga_data !== old_w) begin
         errors++; $display("FAIL rdn_blank_hold: got %h want %h", vga_data, old_w);
      end
      tick();
      vga_rdn = 1'b0;
      tick();
      tick(); #1;
      vectors++;
      if (vga_data !== 19'h7_ABCD) begin
         errors++; $display("FAIL rdn_refetch: got %h want 7abcd", vga_data);
      end
   endtask

   task automatic test_reset_pend();
      logic [18:0] old_w;
      old_w = mem[11'h100];
      vga_rdn = 1'b1;
      do_reset();
      tick();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h100; cpu_wdata = 19'h3_FFFF;
      tick();
      cpu_req = 1'b0; reset = 1'b1;
      #1;
      vectors++;
      if (ram_we !== 1'b0) begin
         errors++; $display("FAIL rstpend_we: got %b want 0", ram_we);
      end
      tick();
      reset = 1'b0;
      #1;
      vectors++;
      if (cpu_ready !== 1'b0 || stall_cnt !== 8'd0 || ram_we !== 1'b0) begin
         errors++;
         $display("FAIL rstpend_after: ready=%b stall=%0d we=%b want 0/0/0", cpu_ready, stall_cnt, ram_we);
      end
      tick();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h100;
      #1;
      vectors++;
      if (cpu_ready !== 1'b0 || mem[11'h100] !== old_w) begin
         errors++;
         $display("FAIL rstpend_dropped: ready=%b mem=%h want 0/%h", cpu_ready, mem[11'h100], old_w);
      end
      tick();
      cpu_req = 1'b0;
      #1;
      vectors++;
      if (ram_addr !== 11'h100 || ram_we !== 1'b0) begin
         errors++; $display("FAIL rstpend_idle_grant: addr=%h we=%b want 100/0", ram_addr, ram_we);
      end
      tick(); #1;
      vectors++;
      if (cpu_ready !== 1'b1 || cpu_rdata !== old_w) begin
         errors++; $display("FAIL rstpend_idle_ack: ready=%b rdata=%h want 1/%h", cpu_ready, cpu_rdata, old_w);
      end
   endtask

   task automatic test_stall_sat();
      int seen;
      seen = 0;
      vga_rdn = 1'b1;
      do_reset();
      tick();
      vga_rdn = 1'b0; vga_addr = 11'h3F0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h055;
      for (int i = 0; i < 300; i++) begin
         tick();
         cpu_req = 1'b0;
         vga_addr = 11'(i + 1);
         #1;
         if (cpu_ready === 1'b1 || ram_addr !== vga_addr) seen++;
      end
      vectors++;
      if (seen !== 0 || stall_cnt !== 8'd255) begin
         errors++; $display("FAIL stall_sat: cpu_slips=%0d stall=%0d want 0/255", seen, stall_cnt);
      end
      tick(); #1;
      vectors++;
      if (ram_addr !== 11'h055) begin
         errors++; $display("FAIL stall_release_grant: addr=%h want 055", ram_addr);
      end
      tick(); #1;
      vectors++;
      if (cpu_ready !== 1'b1 || stall_cnt !== 8'd255) begin
         errors++; $display("FAIL stall_release_ack: ready=%b stall=%0d want 1/255", cpu_ready, stall_cnt);
      end
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 19'(i) ^ 19'h2_A5A5;
      ram_rdata = '0;
      test_reset();
      test_cpu_write();
      test_cpu_read();
      test_contention();
      test_cache_inval();
      test_rdn_fall();
      test_reset_pend();
      test_stall_sat();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
